// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard sequencer
// Purpose: FSM state encoding and E-stage forwarding-select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file read data
  localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - forwarding source select for one E-stage ALU operand
// Purpose: picks M over W over register file for a single source operand.
// Ports:
//   rs_addr_e_i    source register of the E-stage instruction
//   wr_addr_m_i    destination register in M
//   wr_addr_w_i    destination register in W
//   reg_wr_en_m_i  M writes the register file
//   reg_wr_en_w_i  W writes the register file
//   enable_i       forwarding allowed (low during the post-reset purge)
//   sel_o          FWD_RF / FWD_W / FWD_M
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_addr_e_i,
  input  logic [4:0] wr_addr_m_i,
  input  logic [4:0] wr_addr_w_i,
  input  logic       reg_wr_en_m_i,
  input  logic       reg_wr_en_w_i,
  input  logic       enable_i,
  output logic [1:0] sel_o
);

  logic hit_m;
  logic hit_w;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  assign hit_m = reg_wr_en_m_i && (wr_addr_m_i != 5'd0) && (wr_addr_m_i == rs_addr_e_i);
  assign hit_w = reg_wr_en_w_i && (wr_addr_w_i != 5'd0) && (wr_addr_w_i == rs_addr_e_i);

  always_comb begin
    sel_o = FWD_RF;
    if (enable_i) begin
      // M holds the younger write, so it wins when both stages match.
      if (hit_m) begin
        sel_o = FWD_M;
      end else if (hit_w) begin
        sel_o = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward sequencer for the 5-stage RV32I pipeline
// Purpose: post-reset purge, memory-wait freeze with watchdog, redirect and
//   load-use handling, E-stage forwarding selects, optional perf counters.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall_cnt_o / flush_cnt_o).
// Ports:
//   clk_i, rst_n_i                        clock, async active-low reset
//   rs1/rs2_addr_d_i, rs1/rs2_addr_e_i    source registers in D and E
//   wr_addr_e/m/w_i                       destination registers in E, M, W
//   result_src_e_i                        E holds a load
//   reg_wr_en_m_i, reg_wr_en_w_i          M / W write the register file
//   pc_src_e_i                            redirect resolved in E
//   mem_req_m_i, mem_ready_m_i            data-memory handshake in M
//   stall_f/d/e/m_o, flush_d/e/w_o        pipeline register controls
//   forward_a_e_o, forward_b_e_o          ALU operand source selects
//   mem_timeout_o                         sticky watchdog flag
//   stall_cnt_o, flush_cnt_o              performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  rs1_addr_d_i,
  input  logic [4:0]  rs2_addr_d_i,
  input  logic [4:0]  rs1_addr_e_i,
  input  logic [4:0]  rs2_addr_e_i,
  input  logic [4:0]  wr_addr_e_i,
  input  logic [4:0]  wr_addr_m_i,
  input  logic [4:0]  wr_addr_w_i,
  input  logic        result_src_e_i,
  input  logic        reg_wr_en_m_i,
  input  logic        reg_wr_en_w_i,
  input  logic        pc_src_e_i,
  input  logic        mem_req_m_i,
  input  logic        mem_ready_m_i,
  output logic        stall_f_o,
  output logic        stall_d_o,
  output logic        stall_e_o,
  output logic        stall_m_o,
  output logic        flush_d_o,
  output logic        flush_e_o,
  output logic        flush_w_o,
  output logic [1:0]  forward_a_e_o,
  output logic [1:0]  forward_b_e_o,
  output logic        mem_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [15:0] INIT_LAST    = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] init_cnt_q, init_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;

  logic active;
  logic mem_stall;
  logic redirect;
  logic load_use;

  assign active    = (state_q != INIT);
  assign mem_stall = mem_req_m_i && !mem_ready_m_i;
  // A frozen pipeline cannot act on a redirect; it is taken once M releases.
  assign redirect  = active && !mem_stall && pc_src_e_i;
  assign load_use  = result_src_e_i && (wr_addr_e_i != 5'd0) &&
                     ((wr_addr_e_i == rs1_addr_d_i) || (wr_addr_e_i == rs2_addr_d_i));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 16'd1;
        if (init_cnt_q == INIT_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
        end else begin
          if (wait_cnt_q != 16'hFFFF) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
          if (wait_cnt_q == TIMEOUT_LAST) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Control outputs: priority is purge, memory freeze, redirect, load-use.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_w_o = 1'b0;
    if (!active) begin
      stall_f_o = 1'b1;
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_w_o = 1'b1;
    end else if (mem_stall) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      flush_w_o = 1'b1;
    end else if (redirect) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (load_use) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  assign mem_timeout_o = timeout_q;

  fwd_sel u_fwd_a (
    .rs_addr_e_i   (rs1_addr_e_i),
    .wr_addr_m_i   (wr_addr_m_i),
    .wr_addr_w_i   (wr_addr_w_i),
    .reg_wr_en_m_i (reg_wr_en_m_i),
    .reg_wr_en_w_i (reg_wr_en_w_i),
    .enable_i      (active),
    .sel_o         (forward_a_e_o)
  );

  fwd_sel u_fwd_b (
    .rs_addr_e_i   (rs2_addr_e_i),
    .wr_addr_m_i   (wr_addr_m_i),
    .wr_addr_w_i   (wr_addr_w_i),
    .reg_wr_en_m_i (reg_wr_en_m_i),
    .reg_wr_en_w_i (reg_wr_en_w_i),
    .enable_i      (active),
    .sel_o         (forward_b_e_o)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (active && stall_f_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, wr_e, wr_m, wr_w;
    logic       ld_e, wen_m, wen_w, pc_src, mem_req, mem_rdy;
  } in_t;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fwd_a, fwd_b, timeout}
  typedef struct packed {
    logic       sf, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
    logic       to;
  } exp_t;

  typedef struct {
    string       name;
    exp_t        e;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } sb_t;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [11:0] E_IDLE = 12'b0000_000_00_00_0;
  localparam logic [11:0] E_INIT = 12'b1000_111_00_00_0;
  localparam logic [11:0] E_LU   = 12'b1100_010_00_00_0;
  localparam logic [11:0] E_RDIR = 12'b0000_110_00_00_0;
  localparam logic [11:0] E_MEM  = 12'b1111_001_00_00_0;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [4:0]  rs1_addr_d_i = '0, rs2_addr_d_i = '0, rs1_addr_e_i = '0, rs2_addr_e_i = '0;
  logic [4:0]  wr_addr_e_i = '0, wr_addr_m_i = '0, wr_addr_w_i = '0;
  logic        result_src_e_i = 1'b0, reg_wr_en_m_i = 1'b0, reg_wr_en_w_i = 1'b0;
  logic        pc_src_e_i = 1'b0, mem_req_m_i = 1'b0, mem_ready_m_i = 1'b0;
  logic        stall_f_o, stall_d_o, stall_e_o, stall_m_o;
  logic        flush_d_o, flush_e_o, flush_w_o;
  logic [1:0]  forward_a_e_o, forward_b_e_o;
  logic        mem_timeout_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  sb_t         sb_q[$];
  int          checks = 0;
  int          passed = 0;
  int unsigned exp_scnt = 0;
  int unsigned exp_fcnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .rs1_addr_d_i   (rs1_addr_d_i),
    .rs2_addr_d_i   (rs2_addr_d_i),
    .rs1_addr_e_i   (rs1_addr_e_i),
    .rs2_addr_e_i   (rs2_addr_e_i),
    .wr_addr_e_i    (wr_addr_e_i),
    .wr_addr_m_i    (wr_addr_m_i),
    .wr_addr_w_i    (wr_addr_w_i),
    .result_src_e_i (result_src_e_i),
    .reg_wr_en_m_i  (reg_wr_en_m_i),
    .reg_wr_en_w_i  (reg_wr_en_w_i),
    .pc_src_e_i     (pc_src_e_i),
    .mem_req_m_i    (mem_req_m_i),
    .mem_ready_m_i  (mem_ready_m_i),
    .stall_f_o      (stall_f_o),
    .stall_d_o      (stall_d_o),
    .stall_e_o      (stall_e_o),
    .stall_m_o      (stall_m_o),
    .flush_d_o      (flush_d_o),
    .flush_e_o      (flush_e_o),
    .flush_w_o      (flush_w_o),
    .forward_a_e_o  (forward_a_e_o),
    .forward_b_e_o  (forward_b_e_o),
    .mem_timeout_o  (mem_timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  function automatic in_t zin();
    in_t v;
    v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs just after the clock edge and queue the outcome.
  task automatic step(input string name, input in_t i, input exp_t e);
    sb_t s;
    @(posedge clk);
    #1;
    rst_n_i        = i.rst_n;
    rs1_addr_d_i   = i.rs1_d;
    rs2_addr_d_i   = i.rs2_d;
    rs1_addr_e_i   = i.rs1_e;
    rs2_addr_e_i   = i.rs2_e;
    wr_addr_e_i    = i.wr_e;
    wr_addr_m_i    = i.wr_m;
    wr_addr_w_i    = i.wr_w;
    result_src_e_i = i.ld_e;
    reg_wr_en_m_i  = i.wen_m;
    reg_wr_en_w_i  = i.wen_w;
    pc_src_e_i     = i.pc_src;
    mem_req_m_i    = i.mem_req;
    mem_ready_m_i  = i.mem_rdy;
    if (!i.rst_n) begin
      exp_scnt = 0;
      exp_fcnt = 0;
    end
    s.name = name;
    s.e    = e;
    s.scnt = PERF ? exp_scnt : 32'd0;
    s.fcnt = PERF ? exp_fcnt : 32'd0;
    sb_q.push_back(s);
    // Purge cycles (stall_f together with flush_d) are not counted.
    if (i.rst_n && !(e.sf && e.fd)) begin
      if (e.sf) exp_scnt++;
      if (i.pc_src && e.fd) exp_fcnt++;
    end
  endtask

  initial begin : monitor
    sb_t         s;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        s   = sb_q.pop_front();
        got = {stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_d_o, flush_e_o, flush_w_o,
               forward_a_e_o, forward_b_e_o, mem_timeout_o};
        checks++;
        if (got !== s.e || stall_cnt_o !== s.scnt || flush_cnt_o !== s.fcnt) begin
          $display("FAIL %s: got ctrl=%b scnt=%0d fcnt=%0d, want ctrl=%b scnt=%0d fcnt=%0d",
                   s.name, got, stall_cnt_o, flush_cnt_o, s.e, s.scnt, s.fcnt);
        end else begin
          passed++;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    in_t  i;
    exp_t e;

    // Reset held, release, two purge cycles, then RUN.
    i = zin(); i.rst_n = 1'b0;
    step("rst_hold", i, E_INIT);
    i = zin();
    step("init0", i, E_INIT);
    i = zin(); i.pc_src = 1'b1; i.wr_m = 5'd7; i.wen_m = 1'b1; i.rs1_e = 5'd7;
    step("init1_no_fwd", i, E_INIT);
    i = zin();
    step("run_idle", i, E_IDLE);

    // Load-use hazards.
    i = zin(); i.ld_e = 1'b1; i.wr_e = 5'd5; i.rs2_d = 5'd5;
    step("load_use_rs2", i, E_LU);
    i = zin();
    step("after_load", i, E_IDLE);
    i = zin(); i.ld_e = 1'b1; i.wr_e = 5'd0;
    step("load_x0", i, E_IDLE);
    i = zin(); i.ld_e = 1'b1; i.wr_e = 5'd9; i.rs1_d = 5'd9;
    step("load_use_rs1", i, E_LU);

    // Redirect beats load-use.
    i = zin(); i.pc_src = 1'b1; i.ld_e = 1'b1; i.wr_e = 5'd5; i.rs2_d = 5'd5;
    step("redir_over_lu", i, E_RDIR);

    // Memory wait of 3 cycles with a redirect pending throughout.
    i = zin(); i.mem_req = 1'b1; i.pc_src = 1'b1;
    for (int k = 0; k < 3; k++) step("mem_wait", i, E_MEM);
    i.mem_rdy = 1'b1;
    step("mem_done_redir", i, E_RDIR);

    // Forwarding priority and x0 handling.
    i = zin(); i.wr_m = 5'd7; i.wr_w = 5'd7; i.wen_m = 1'b1; i.wen_w = 1'b1;
    i.rs1_e = 5'd7; i.rs2_e = 5'd7;
    e = E_IDLE; e.fa = 2'b10; e.fb = 2'b10;
    step("fwd_m_wins", i, e);
    i.wen_m = 1'b0;
    e.fa = 2'b01; e.fb = 2'b01;
    step("fwd_w", i, e);
    i = zin(); i.wr_m = 5'd0; i.wr_w = 5'd0; i.wen_m = 1'b1; i.wen_w = 1'b1;
    i.rs1_e = 5'd0; i.rs2_e = 5'd7;
    step("fwd_x0", i, E_IDLE);
    i = zin(); i.wr_m = 5'd3; i.wr_w = 5'd7; i.wen_m = 1'b1; i.wen_w = 1'b1;
    i.rs1_e = 5'd7; i.rs2_e = 5'd3;
    e = E_IDLE; e.fa = 2'b01; e.fb = 2'b10;
    step("fwd_split", i, e);

    // Watchdog: entry cycle plus four MEM_WAIT cycles, then the flag shows.
    i = zin(); i.mem_req = 1'b1; i.wr_w = 5'd7; i.wen_w = 1'b1; i.rs1_e = 5'd7;
    e = E_MEM; e.fa = 2'b01;
    for (int k = 0; k < 5; k++) step("tmo_pending", i, e);
    e.to = 1'b1;
    step("tmo_set", i, e);
    step("tmo_still_stall", i, e);
    i.mem_rdy = 1'b1;
    e = E_IDLE; e.fa = 2'b01; e.to = 1'b1;
    step("tmo_sticky_ready", i, e);
    i = zin();
    e = E_IDLE; e.to = 1'b1;
    step("tmo_sticky_idle", i, e);

    // Only reset clears the flag.
    i = zin(); i.rst_n = 1'b0;
    step("rst2_hold", i, E_INIT);
    i = zin();
    step("rst2_init0", i, E_INIT);
    step("rst2_init1", i, E_INIT);
    step("rst2_run", i, E_IDLE);

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end else begin
      passed++;
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core.
- Generates the stall and flush controls for the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding selects.
- Sequences a post-reset pipeline purge and multi-cycle data-memory waits, with a timeout watchdog.
- Sits beside the datapath; it reads stage register addresses and control bits and drives each pipeline register's stall_i/flush_i.

Parameters:
- INIT_CYCLES, 2, number of cycles after reset during which D and E are flushed and F is held.
- MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout_o sets; range 1..65535.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- rs1_addr_d_i  in  5  Rs1 of the instruction in D.
- rs2_addr_d_i  in  5  Rs2 of the instruction in D.
- rs1_addr_e_i  in  5  Rs1 of the instruction in E.
- rs2_addr_e_i  in  5  Rs2 of the instruction in E.
- wr_addr_e_i  in  5  Rd in E.
- wr_addr_m_i  in  5  Rd in M.
- wr_addr_w_i  in  5  Rd in W.
- result_src_e_i  in  1  E holds a load.
- reg_wr_en_m_i  in  1  M writes the register file.
- reg_wr_en_w_i  in  1  W writes the register file.
- pc_src_e_i  in  1  taken branch or jump resolved in E.
- mem_req_m_i  in  1  M is accessing data memory.
- mem_ready_m_i  in  1  data memory completes this cycle.
- stall_f_o  out  1  hold PC.
- stall_d_o  out  1  hold F/D register.
- stall_e_o  out  1  hold D/E register.
- stall_m_o  out  1  hold E/M register.
- flush_d_o  out  1  bubble into F/D.
- flush_e_o  out  1  bubble into D/E.
- flush_w_o  out  1  bubble into M/W.
- forward_a_e_o  out  2  ALU operand A source: 00 register file, 01 W result, 10 M ALU result.
- forward_b_e_o  out  2  ALU operand B source; same encoding.
- mem_timeout_o  out  1  sticky watchdog flag.
- stall_cnt_o  out  32  stall-cycle counter.
- flush_cnt_o  out  32  redirect counter.

Behaviour:
- FSM states: INIT, RUN, MEM_WAIT. Reset is asynchronous and sets state=INIT, init_cnt=0, wait_cnt=0, mem_timeout_o=0, and all counters to 0.
- Control outputs are combinational from state and inputs; every stall/flush takes effect on the register's next clock edge.
- INIT:
  - Outputs: stall_f=1, flush_d=1, flush_e=1, flush_w=1; other stalls 0; forward selects 00.
  - init_cnt increments each cycle.
  - Transition to RUN after INIT_CYCLES cycles; all INIT outputs persist through the final INIT cycle.
- Memory stall, mem_stall = mem_req_m_i & !mem_ready_m_i:
  - Active in RUN and MEM_WAIT.
  - Outputs: stall_f, stall_d, stall_e, stall_m = 1; flush_w=1; flush_d=0; flush_e=0.
  - Has the highest priority: a pending branch or load-use waits, because its stage is frozen.
- RUN to MEM_WAIT when mem_stall, with wait_cnt reset to 0.
- MEM_WAIT:
  - wait_cnt increments while mem_stall and saturates.
  - When wait_cnt reaches MEM_TIMEOUT-1 with mem_stall still 1, mem_timeout_o sets and stays set until reset; stalling continues regardless.
  - Return to RUN in the cycle mem_ready_m_i=1 (mem_stall=0); that cycle's outputs follow the RUN rules.
- Redirect (no mem_stall): pc_src_e_i drives flush_d=1 and flush_e=1, with stall_f=0 and stall_d=0.
  - Redirect overrides load-use, because the dependent D instruction is squashed.
- Load-use (no mem_stall, no redirect):
  - Condition: result_src_e_i & wr_addr_e_i!=0 & (wr_addr_e_i==rs1_addr_d_i | wr_addr_e_i==rs2_addr_d_i).
  - Outputs: stall_f=1, stall_d=1, flush_e=1. Exactly one bubble per load.
- Forwarding, per operand:
  - 10 if reg_wr_en_m_i & wr_addr_m_i!=0 & match.
  - Else 01 if reg_wr_en_w_i & wr_addr_w_i!=0 & match.
  - Else 00.
  - M wins when both M and W match. x0 is never forwarded. Selects are valid in all states except INIT.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cnt_o increments each cycle stall_f_o=1 in RUN or MEM_WAIT.
  - flush_cnt_o increments each cycle pc_src_e_i causes a flush.
  - Both counters wrap at 2^32.
- When undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg:
  - state enum typedef (INIT, RUN, MEM_WAIT).
  - forwarding-select localparams FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module, fwd_sel: combinational M/W priority match, instantiated once per operand.
- The FSM and counters stay in hazard_ctrl.

Test Plan:
- Reset release with INIT_CYCLES=2 -> stall_f=1 and flush_d=flush_e=1 for exactly 2 cycles, then RUN with all stalls 0.
- Load: wr_addr_e=5, result_src_e=1, rs2_addr_d=5 -> stall_f=stall_d=flush_e=1 for one cycle. Repeat with wr_addr_e=0 -> no stall.
- Redirect and load-use asserted together -> flush_d=flush_e=1, stall_f=0; flush_cnt +1 with the macro defined.
- mem_req=1, mem_ready=0 for 3 cycles, then 1:
  - stall_f/d/e/m and flush_w=1 for 3 cycles; 0 in the 4th.
  - A pc_src_e held during the wait flushes only in the 4th cycle.
- MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_o rises after 4 MEM_WAIT cycles, stays set after ready, clears only on rst_n_i.
- wr_addr_m=wr_addr_w=7, both write enables 1, rs1_e=7 -> forward_a=10. Drop reg_wr_en_m -> 01. rs1_e=0 -> 00.
